alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single clocked 32-bit ALU (operands `a`, `b`, shift amount `r`, 4-bit `opcode`, 64-bit `out`) between two requesters. It accepts one operation at a time via valid/ready, drives the ALU for its fixed latency and captures the 64-bit result. The result is returned to the winning requester with response backpressure. It sits between the issue logic and the ALU instance, which stays outside this block.

## Interface
- `ALU_LAT`, 1: ALU cycles from stable inputs to valid `out` (1..7).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 2: per-requester operation request.
- `req_ready` out 2: per-requester accept; one-hot or zero.
- `req_a` in 64: operand a, `{req1,req0}` 32 bits each.
- `req_b` in 64: operand b, same packing.
- `req_r` in 10: shift amount, 5 bits each.
- `req_op` in 8: opcode, 4 bits each.
- `resp_valid` out 2: result valid; only owner's bit set.
- `resp_ready` in 2: per-requester result accept.
- `resp_data` out 64: captured ALU result.
- `alu_a`, `alu_b` out 32: to ALU.
- `alu_r` out 5: to ALU.
- `alu_opcode` out 4: to ALU.
- `alu_out` in 64: from ALU.
- `busy` out 1: high in any state but IDLE.
- `grant_cnt` out 32: `{cnt1,cnt0}`, only with `ALU_ARB_STATS_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate among `req_valid`.
  - Single requester wins outright.
  - When both are valid, the one not granted last time wins (round-robin). `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready[w]` is asserted combinationally in IDLE for the winner `w`.
  - On handshake: latch operands into the op registers, latch `owner=w`, toggle `last_grant` to `w`, load the latency counter with `ALU_LAT`, go to EXEC.
- EXEC: op registers drive `alu_*` unchanged. The counter decrements each cycle. In the cycle the counter is 1, `resp_data <= alu_out`, then go to RESP.
- RESP: `resp_valid[owner]=1` with `resp_data` held stable. On `resp_ready[owner]`, go to IDLE. `resp_ready` of the non-owner is ignored.
- `req_ready` is 0 outside IDLE. Requests wait; no queuing.
- `req_valid` dropping before handshake is legal. No operation is recorded.

## Timing
- Accept at cycle 0. ALU inputs are stable from cycle 1. `alu_out` is sampled at the end of cycle `ALU_LAT`.
- `resp_valid` is high from cycle `ALU_LAT+1`.
- With `resp_ready` held high: IDLE at `ALU_LAT+2`, next accept at the earliest that cycle. Minimum issue interval is `ALU_LAT+2` cycles.
- Reset values:
  - State IDLE; `req_ready`=0, `resp_valid`=0, `busy`=0.
  - `resp_data`=0, `alu_a`/`alu_b`/`alu_r`/`alu_opcode`=0.
  - `owner`=0, `last_grant`=1, counters 0.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, and the block is in IDLE the next cycle. The requester must reissue.
- `resp_data` is unchanged except at the EXEC capture edge. Full 64-bit width is passed through with no truncation.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Per-requester 16-bit grant counters, incremented on each accepted handshake.
  - Counters saturate at 16'hFFFF and clear on reset.
  - Exposed on `grant_cnt`.
- `ALU_ARB_STATS_EN` undefined: counters and the `grant_cnt` port are absent. All other behaviour is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - Width constants: `DATA_W`=32, `RES_W`=64, `SHAMT_W`=5, `OP_W`=4, `NREQ`=2.
  - The FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- Sub-module `rr_arb2`: combinational 2-way round-robin picker taking `req_valid` and `last_grant`, returning a one-hot grant.

## Test plan
- Single request, req0 `a`=30, `b`=20, `op`=0 (add), `ALU_LAT`=1 -> `req_ready[0]` at cycle 0; `resp_valid`=2'b01 at cycle 2 with `resp_data`=64'd50; `busy` high for cycles 1-2.
- Both valid at the same cycle after reset, repeated 4 times with `resp_ready`=2'b11 -> grant order 0,1,0,1; each `resp_valid` goes to the correct owner only.
- Backpressure: `resp_ready[1]`=0 for 5 cycles during a req1 op with `op`=4, `a`=34, `r`=4 -> `resp_valid`=2'b10 and `resp_data` stay stable; req0 is held with `req_ready`=0; accepted the cycle after release plus one.
- `rst_n`=0 asserted during EXEC -> next cycle all outputs are at reset values; no response is ever issued for the dropped op.
- `ALU_LAT`=3 -> `resp_valid` exactly 4 cycles after accept; `alu_*` are stable across all EXEC cycles.
- With `ALU_ARB_STATS_EN`: 3 grants to req0 and 1 to req1 -> `grant_cnt`={16'd1,16'd3}. Forcing the counter to 16'hFFFF and granting once more leaves it at 16'hFFFF.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared widths, FSM encoding and operation payload for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RES_W   = 64;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] r;
    logic [OP_W-1:0]    op;
  } alu_op_t;

  function automatic logic [NREQ-1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not granted last.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            last_grant_i,
  output logic [NREQ-1:0] grant_c_o
);

  always_comb begin
    grant_c_o = '0;
    unique case (req_valid_i)
      2'b01:   grant_c_o = 2'b01;
      2'b10:   grant_c_o = 2'b10;
      2'b11:   grant_c_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external clocked ALU between two requesters: accept, run for ALU_LAT, return result.
// Optional per-requester grant counters on grant_cnt when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_a,
  input  logic [NREQ*DATA_W-1:0]  req_b,
  input  logic [NREQ*SHAMT_W-1:0] req_r,
  input  logic [NREQ*OP_W-1:0]    req_op,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [RES_W-1:0]        resp_data,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [SHAMT_W-1:0]      alu_r,
  output logic [OP_W-1:0]         alu_opcode,
  input  logic [RES_W-1:0]        alu_out,
  output logic                    busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]   grant_cnt
`endif
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  alu_op_t          op_q, op_d;
  logic [RES_W-1:0] resp_q, resp_d;

  logic [NREQ-1:0]  grant;
  logic             win;
  logic             hs;
  alu_op_t          sel_op;

  rr_arb2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .grant_c_o    (grant)
  );

  // Ready is offered only in IDLE and never while reset is applied.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
  assign hs        = |req_ready;
  assign win       = grant[1];
  assign sel_op    = '{a:  win ? req_a[DATA_W +: DATA_W]   : req_a[0 +: DATA_W],
                       b:  win ? req_b[DATA_W +: DATA_W]   : req_b[0 +: DATA_W],
                       r:  win ? req_r[SHAMT_W +: SHAMT_W] : req_r[0 +: SHAMT_W],
                       op: win ? req_op[OP_W +: OP_W]      : req_op[0 +: OP_W]};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = sel_op;
          owner_d = win;
          last_d  = win;
          cnt_d   = LAT_W'(ALU_LAT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - LAT_W'(1);
        // Last latency cycle: the ALU output is valid at this edge.
        if (cnt_q == LAT_W'(1)) begin
          resp_d  = alu_out;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      resp_q  <= resp_d;
    end
  end

  assign resp_valid = (state_q == RESP) ? idx2onehot(owner_q) : '0;
  assign resp_data  = resp_q;
  assign busy       = (state_q != IDLE);
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_r      = op_q.r;
  assign alu_opcode = op_q.op;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] gcnt_q, gcnt_d;

  // Saturating grant counters, one per requester.
  always_comb begin
    gcnt_d = gcnt_q;
    if (hs && gcnt_q[win] != '1) gcnt_d[win] = gcnt_q[win] + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (ALU_LAT 1 and 3), transaction-level model plus directed checks.
module tb_alu_arbiter;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [1:0]  rv   [2];
  logic [63:0] ra   [2];
  logic [63:0] rb   [2];
  logic [9:0]  rr   [2];
  logic [7:0]  rop  [2];
  logic [1:0]  rdy  [2];
  logic [1:0]  qrdy [2];
  logic [1:0]  rsv  [2];
  logic [63:0] rsd  [2];
  logic [63:0] aout [2];
  logic [31:0] aa   [2];
  logic [31:0] ab   [2];
  logic [4:0]  ar   [2];
  logic [3:0]  aop  [2];
  logic        bsy  [2];
`ifdef ALU_ARB_STATS_EN
  logic [31:0] gcnt [2];
`endif
  logic [63:0] p1, p2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.ALU_LAT(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(qrdy[0]),
    .req_a(ra[0]), .req_b(rb[0]), .req_r(rr[0]), .req_op(rop[0]),
    .resp_valid(rsv[0]), .resp_ready(rdy[0]), .resp_data(rsd[0]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_r(ar[0]), .alu_opcode(aop[0]),
    .alu_out(aout[0]), .busy(bsy[0])
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt(gcnt[0])
`endif
  );

  alu_arbiter #(.ALU_LAT(LAT1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(qrdy[1]),
    .req_a(ra[1]), .req_b(rb[1]), .req_r(rr[1]), .req_op(rop[1]),
    .resp_valid(rsv[1]), .resp_ready(rdy[1]), .resp_data(rsd[1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_r(ar[1]), .alu_opcode(aop[1]),
    .alu_out(aout[1]), .busy(bsy[1])
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt(gcnt[1])
`endif
  );

  function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] r);
    case (op)
      4'd0:    return 64'(a) + 64'(b);
      4'd1:    return 64'(a) - 64'(b);
      4'd2:    return 64'(a) * 64'(b);
      4'd4:    return 64'(a) << r;
      4'd5:    return 64'(a >> r);
      default: return 64'(a ^ b);
    endcase
  endfunction

  // External ALU stand-ins: combinational for latency 1, two stages for latency 3.
  always @(posedge clk) begin
    p1 <= alu_f(aop[1], aa[1], ab[1], ar[1]);
    p2 <= p1;
  end
  always_comb begin
    aout[0] = alu_f(aop[0], aa[0], ab[0], ar[0]);
    aout[1] = p2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Transaction model: an accepted op is answered from age LAT+1 until its owner takes it.
  bit          m_act  [2];
  int          m_age  [2];
  bit          m_own  [2];
  bit          m_last [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [4:0]  m_r    [2];
  logic [3:0]  m_op   [2];
  logic [63:0] m_res  [2];
  logic [63:0] m_shown[2];

  always @(negedge clk) begin : cmp
    logic [1:0]  e_rdy, e_rv;
    logic [63:0] e_d;
    bit          rph, w;
    for (int k = 0; k < 2; k++) begin
      rph   = m_act[k] && (m_age[k] >= int'(lat_of(k)) + 1);
      e_rdy = (!m_act[k] && rst_n) ? pick(rv[k], m_last[k]) : 2'b00;
      e_rv  = rph ? (m_own[k] ? 2'b10 : 2'b01) : 2'b00;
      e_d   = rph ? m_res[k] : m_shown[k];
      if (chk_en) begin
        chk($sformatf("k%0d req_ready", k),  64'(qrdy[k]), 64'(e_rdy));
        chk($sformatf("k%0d resp_valid", k), 64'(rsv[k]),  64'(e_rv));
        chk($sformatf("k%0d resp_data", k),  rsd[k],       e_d);
        chk($sformatf("k%0d busy", k),       64'(bsy[k]),  64'(m_act[k]));
        chk($sformatf("k%0d alu_a", k),      64'(aa[k]),   64'(m_a[k]));
        chk($sformatf("k%0d alu_b", k),      64'(ab[k]),   64'(m_b[k]));
        chk($sformatf("k%0d alu_r", k),      64'(ar[k]),   64'(m_r[k]));
        chk($sformatf("k%0d alu_opcode", k), 64'(aop[k]),  64'(m_op[k]));
      end
      if (!rst_n) begin
        m_act[k] = 1'b0; m_age[k] = 0; m_own[k] = 1'b0; m_last[k] = 1'b1;
        m_a[k] = '0; m_b[k] = '0; m_r[k] = '0; m_op[k] = '0; m_res[k] = '0; m_shown[k] = '0;
      end else if (!m_act[k]) begin
        if (e_rdy != 2'b00) begin
          w = e_rdy[1];
          m_act[k] = 1'b1; m_age[k] = 1; m_own[k] = w; m_last[k] = w;
          m_a[k]  = w ? ra[k][63:32] : ra[k][31:0];
          m_b[k]  = w ? rb[k][63:32] : rb[k][31:0];
          m_r[k]  = w ? rr[k][9:5]   : rr[k][4:0];
          m_op[k] = w ? rop[k][7:4]  : rop[k][3:0];
          m_res[k] = alu_f(m_op[k], m_a[k], m_b[k], m_r[k]);
        end
      end else if (rph && rdy[k][m_own[k]]) begin
        m_act[k] = 1'b0; m_shown[k] = m_res[k];
      end else begin
        m_age[k]++;
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int k, input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [3:0] op);
    rv[k][who] = 1'b1;
    if (who == 1) begin
      ra[k][63:32] = a; rb[k][63:32] = b; rr[k][9:5] = r; rop[k][7:4] = op;
    end else begin
      ra[k][31:0] = a; rb[k][31:0] = b; rr[k][4:0] = r; rop[k][3:0] = op;
    end
  endtask

  task automatic wait_ready(input int k, input logic [1:0] mask, output int acc, output logic [1:0] got);
    got = 2'b00; acc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((qrdy[k] & mask) != 2'b00) begin got = qrdy[k]; acc = cyc; return; end
    end
    checks++; errors++;
    $display("FAIL timeout k%0d: req_ready got %b expected mask %b", k, qrdy[k], mask);
  endtask

  task automatic wait_resp(input int k);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsv[k] != 2'b00) return;
    end
    checks++; errors++;
    $display("FAIL timeout k%0d: resp_valid got %b expected nonzero", k, rsv[k]);
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!bsy[k]) return;
    end
    checks++; errors++;
    $display("FAIL timeout k%0d: busy got 1 expected 0", k);
  endtask

  task automatic do_reset();
    sync(); rst_n = 1'b0;
    sync(); rst_n = 1'b1;
  endtask

  task automatic run_op(input int k, input int who, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [3:0] op, input logic [63:0] exp);
    int acc; logic [1:0] got;
    sync(); set_req(k, who, a, b, r, op);
    wait_ready(k, (who == 1) ? 2'b10 : 2'b01, acc, got);
    sync(); rv[k] = 2'b00;
    wait_resp(k);
    chk($sformatf("vec k%0d op%0d data", k, op), rsd[k], exp);
    wait_idle(k);
  endtask

  logic [31:0] va   [4] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_0000};
  logic [31:0] vb   [4] = '{32'd9, 32'hFFFF_FFFF, 32'h0, 32'h0F0F_0000};
  logic [4:0]  vr   [4] = '{5'd0, 5'd0, 5'd31, 5'd0};
  logic [3:0]  vop  [4] = '{4'd1, 4'd2, 4'd5, 4'd7};
  logic [63:0] vexp [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFE_0000_0001,
                            64'd1, 64'h0000_0000_FFFF_0000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, c0;
    logic [1:0] got;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = '0; ra[k] = '0; rb[k] = '0; rr[k] = '0; rop[k] = '0; rdy[k] = 2'b11;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst req_ready", 64'(qrdy[0]), 64'd0);
    chk("rst resp_valid", 64'(rsv[0]), 64'd0);
    chk("rst busy", 64'(bsy[0]), 64'd0);
    chk("rst resp_data", rsd[0], 64'd0);
    chk("rst alu_a", 64'(aa[1]), 64'd0);

    // Single request, 30 + 20, latency 1
    sync(); set_req(0, 0, 32'd30, 32'd20, 5'd0, 4'd0); c0 = cyc;
    wait_ready(0, 2'b01, acc, got);
    chk("t1 grant", 64'(got), 64'h1);
    chk("t1 accept cycle", 64'(acc), 64'(c0));
    sync(); rv[0] = 2'b00;
    @(negedge clk);
    chk("t1 busy c1", 64'(bsy[0]), 64'd1);
    chk("t1 resp_valid c1", 64'(rsv[0]), 64'd0);
    @(negedge clk);
    chk("t1 resp_valid c2", 64'(rsv[0]), 64'h1);
    chk("t1 resp_data", rsd[0], 64'd50);
    chk("t1 busy c2", 64'(bsy[0]), 64'd1);
    @(negedge clk);
    chk("t1 busy c3", 64'(bsy[0]), 64'd0);

    // Ties after reset alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sync();
      set_req(0, 0, 32'(i + 1), 32'd100, 5'd0, 4'd0);
      set_req(0, 1, 32'(i + 1), 32'd100, 5'd0, 4'd0);
      wait_ready(0, 2'b11, acc, got);
      chk($sformatf("tie%0d grant", i), 64'(got), (i % 2 == 0) ? 64'h1 : 64'h2);
      sync(); rv[0] = 2'b00;
      wait_resp(0);
      chk($sformatf("tie%0d resp_valid", i), 64'(rsv[0]), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("tie%0d resp_data", i), rsd[0], 64'(101 + i));
      wait_idle(0);
    end

    // Backpressure on requester 1 while requester 0 waits
    sync(); rdy[0] = 2'b01; set_req(0, 1, 32'd34, 32'd0, 5'd4, 4'd4);
    wait_ready(0, 2'b10, acc, got);
    sync(); rv[0][1] = 1'b0; set_req(0, 0, 32'd1, 32'd2, 5'd0, 4'd0);
    wait_resp(0);
    for (int j = 0; j < 5; j++) begin
      if (j != 0) @(negedge clk);
      chk("bp resp_valid", 64'(rsv[0]), 64'h2);
      chk("bp resp_data", rsd[0], 64'd544);
      chk("bp req_ready", 64'(qrdy[0]), 64'd0);
    end
    sync(); rdy[0] = 2'b11;
    @(negedge clk);
    chk("bp release req_ready", 64'(qrdy[0]), 64'd0);
    @(negedge clk);
    chk("bp next accept", 64'(qrdy[0]), 64'h1);
    sync(); rv[0] = 2'b00;
    wait_resp(0);
    chk("bp req0 data", rsd[0], 64'd3);
    wait_idle(0);

    // Latency 3: response exactly 4 cycles after accept, ALU inputs stable in EXEC
    sync(); set_req(1, 1, 32'd6, 32'd7, 5'd0, 4'd2);
    wait_ready(1, 2'b10, acc, got);
    sync(); rv[1] = 2'b00;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk("l3 resp_valid early", 64'(rsv[1]), 64'd0);
      chk("l3 alu_a", 64'(aa[1]), 64'd6);
      chk("l3 alu_b", 64'(ab[1]), 64'd7);
      chk("l3 alu_opcode", 64'(aop[1]), 64'd2);
    end
    @(negedge clk);
    chk("l3 resp cycle", 64'(cyc - acc), 64'd4);
    chk("l3 resp_valid", 64'(rsv[1]), 64'h2);
    chk("l3 resp_data", rsd[1], 64'd42);
    wait_idle(1);

    // Reset during EXEC drops the operation
    sync(); set_req(1, 0, 32'd7, 32'd8, 5'd0, 4'd0);
    wait_ready(1, 2'b01, acc, got);
    sync(); rv[1] = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    sync(); rst_n = 1'b1;
    @(negedge clk);
    chk("rx busy", 64'(bsy[1]), 64'd0);
    chk("rx resp_valid", 64'(rsv[1]), 64'd0);
    chk("rx resp_data", rsd[1], 64'd0);
    chk("rx alu_a", 64'(aa[1]), 64'd0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("rx no response", 64'(rsv[1]), 64'd0);
    end

    // Assorted operations on both latencies
    for (int i = 0; i < 4; i++) run_op(i % 2, (i / 2) % 2, va[i], vb[i], vr[i], vop[i], vexp[i]);

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_op(0, 0, 32'd1, 32'd1, 5'd0, 4'd0, 64'd2);
    run_op(0, 1, 32'd1, 32'd1, 5'd0, 4'd0, 64'd2);
    chk("stats count", 64'(gcnt[0]), 64'h0001_0003);
    sync();
    force dut0.gcnt_q = {16'd1, 16'hFFFF};
    @(negedge clk);
    release dut0.gcnt_q;
    run_op(0, 0, 32'd1, 32'd1, 5'd0, 4'd0, 64'd2);
    chk("stats saturate", 64'(gcnt[0]), 64'h0001_FFFF);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
